rgb_fifo_burst_reader: RTL

//  Read-side master for the 16-bit RGB pixel dual-clock FIFO. Lives in the FIFO rdclk domain.

---
 rtl/isp_fifo_rd_pkg.sv | 25 ++
 rtl/rgb_fifo_burst_reader_if.sv | 30 +++
 rtl/rd_skid_buf.sv | 47 ++++
 rtl/rgb_fifo_burst_reader.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/isp_fifo_rd_pkg.sv
// Shared types and sizes for the RGB pixel FIFO read-side burst master.
// Also holds the frame address wrap helper.
package isp_fifo_rd_pkg;

    localparam int PIX_W      = 16;
    localparam int FIFO_DEPTH = 64;
    localparam int USEDW_W    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } rd_state_t;

    // Next burst start address; any result at or past the frame end restarts at base.
    function automatic logic [31:0] wrap_addr(input logic [31:0] addr,
                                              input logic [31:0] len,
                                              input logic [31:0] base,
                                              input logic [31:0] frame_words);
        logic [31:0] sum;
        sum = addr + len;
        return (sum >= base + frame_words) ? base : sum;
    endfunction

endpackage

// File: rtl/rgb_fifo_burst_reader_if.sv
// Burst request/grant channel plus pixel stream from the FIFO reader to the
// frame-buffer writer.
interface rgb_fifo_burst_reader_if #(
    parameter int ADDR_W = 22
) ();
    import isp_fifo_rd_pkg::*;

    // burst_req is held with burst_addr/burst_len stable until a one-cycle
    // burst_gnt; a pixel moves on every cycle with out_valid && out_ready, and
    // out_data is held while out_valid is high and out_ready is low.
    logic                burst_req;
    logic [ADDR_W-1:0]   burst_addr;
    logic [5:0]          burst_len;
    logic                burst_gnt;
    logic [PIX_W-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                burst_done;

    modport master (
        output burst_req, burst_addr, burst_len, out_data, out_valid, burst_done,
        input  burst_gnt, out_ready
    );

    modport slave (
        input  burst_req, burst_addr, burst_len, out_data, out_valid, burst_done,
        output burst_gnt, out_ready
    );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry pixel queue between the FIFO read port and the output stream.
// Push and pop may happen in the same cycle; order is preserved.
module rd_skid_buf
    import isp_fifo_rd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [1:0]       occ_o,
    output logic [PIX_W-1:0] head_o
);

    logic [PIX_W-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;

    always_comb begin
        occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/rgb_fifo_burst_reader.sv
// Read-side burst master for the RGB pixel dual-clock FIFO (rdclk domain).
// Define FIFO_RD_STATS_EN to count FIFO-full cycles on ovf_cnt.
module rgb_fifo_burst_reader
    import isp_fifo_rd_pkg::*;
#(
    parameter int BURST_LEN   = 16,
    parameter int ADDR_W      = 22,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 307200
) (
    input  logic                    rdclk,
    input  logic                    aclr,
    input  logic                    frame_start,
    input  logic                    flush,
    input  logic [PIX_W-1:0]        fifo_q,
    input  logic                    fifo_rdempty,
    input  logic                    fifo_rdfull,
    input  logic [USEDW_W-1:0]      fifo_rdusedw,
    output logic                    fifo_rdreq,
    rgb_fifo_burst_reader_if.master bus,
    output logic                    busy,
    output logic [15:0]             ovf_cnt,
    output rd_state_t               dbg_state_o,
    output logic [1:0]              dbg_occ_o
);

    localparam logic [5:0] BURST_LEN_W = 6'(BURST_LEN);

    rd_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        len_q;
    logic [5:0]        rd_left_q;
    logic [5:0]        sent_q;
    logic              rdreq_q;
    logic              flush_pend_q;
    logic              fs_pend_q;
    logic              done_q;

    logic [1:0]        occ;
    logic [PIX_W-1:0]  head;
    logic              pop;
    logic [2:0]        occ_proj;
    logic              rdreq_d;

    // A read issued now lands in the skid next cycle, so count the one in
    // flight and only read when that leaves room for this one as well.
    assign pop        = (occ != 2'd0) && bus.out_ready;
    assign occ_proj   = {1'b0, occ} + {2'b00, rdreq_q} - {2'b00, pop};
    assign rdreq_d    = (state_q == XFER) && (rd_left_q != 6'd0) && !fifo_rdempty
                        && (occ_proj <= 3'd1);
    assign fifo_rdreq = rdreq_d;

    rd_skid_buf u_skid (
        .clk_i  (rdclk),
        .rst_i  (aclr),
        .push_i (rdreq_q),
        .pop_i  (pop),
        .din_i  (fifo_q),
        .occ_o  (occ),
        .head_o (head)
    );

    always_ff @(posedge rdclk) begin
        if (aclr) begin
            state_q      <= IDLE;
            addr_q       <= ADDR_W'(BASE_ADDR);
            len_q        <= 6'd0;
            rd_left_q    <= 6'd0;
            sent_q       <= 6'd0;
            rdreq_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            fs_pend_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rdreq_q      <= rdreq_d;
            done_q       <= 1'b0;
            flush_pend_q <= flush_pend_q | flush;
            fs_pend_q    <= fs_pend_q | frame_start;
            case (state_q)
                IDLE: begin
                    // A pending flush drains into the old frame before the
                    // address is rewound; a new pulse in the clearing cycle survives.
                    if (flush_pend_q && (fifo_rdusedw != '0)) begin
                        len_q   <= fifo_rdusedw;
                        state_q <= REQ;
                    end else if (flush_pend_q && fifo_rdempty) begin
                        flush_pend_q <= flush;
                    end else if (fs_pend_q) begin
                        addr_q    <= ADDR_W'(BASE_ADDR);
                        fs_pend_q <= frame_start;
                    end else if (fifo_rdusedw >= BURST_LEN_W) begin
                        len_q   <= BURST_LEN_W;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus.burst_gnt) begin
                        rd_left_q <= len_q;
                        sent_q    <= 6'd0;
                        state_q   <= XFER;
                    end
                end
                XFER: begin
                    if (rdreq_d) begin
                        rd_left_q <= rd_left_q - 6'd1;
                    end
                    if (pop) begin
                        sent_q <= sent_q + 6'd1;
                        if (sent_q + 6'd1 == len_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            addr_q  <= ADDR_W'(wrap_addr(32'(addr_q), 32'(len_q),
                                                         32'(BASE_ADDR), 32'(FRAME_WORDS)));
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.burst_req  = (state_q == REQ);
    assign bus.burst_addr = addr_q;
    assign bus.burst_len  = len_q;
    assign bus.out_data   = head;
    assign bus.out_valid  = (occ != 2'd0);
    assign bus.burst_done = done_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state_o    = state_q;
    assign dbg_occ_o      = occ;

`ifdef FIFO_RD_STATS_EN
    logic [15:0] ovf_q;

    always_ff @(posedge rdclk) begin
        if (aclr || frame_start) begin
            ovf_q <= 16'h0000;
        end else if (fifo_rdfull && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    logic unused_rdfull;
    assign unused_rdfull = fifo_rdfull;
    assign ovf_cnt       = 16'h0000;
`endif

endmodule
